// File: rtl/vlsu_txn_sched.sv
// Vector LSU AXI transaction scheduler: arbitrates load/store bursts onto AR/AW, enforces
// read/write ordering by draining before a direction switch. Optional macro: VLSU_TXN_SCHED_PERF_EN.
module vlsu_txn_sched #(
   parameter int unsigned MaxOutstanding  = 8,
   parameter int unsigned SwitchThreshold = 4,
   localparam int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                ld_req_valid_i,
   output logic                ld_req_ready_o,
   input  logic                st_req_valid_i,
   output logic                st_req_ready_o,
   output logic                ar_valid_o,
   input  logic                ar_ready_i,
   output logic                aw_valid_o,
   input  logic                aw_ready_i,
   input  logic                r_last_hs_i,
   input  logic                b_hs_i,
   output logic [CntWidth-1:0] ld_outstanding_o,
   output logic [CntWidth-1:0] st_outstanding_o,
   output logic                idle_o,
   output logic                err_o,
   output logic [31:0]         perf_switches_o
);

   localparam int unsigned GntWidth = $clog2(SwitchThreshold + 1);
   localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);
   localparam logic [GntWidth-1:0] ThrCnt = GntWidth'(SwitchThreshold);

   typedef enum logic [2:0] {StIdle, StLd, StSt, StDrainLd, StDrainSt} state_e;

   state_e              state_q, state_d;
   logic [CntWidth-1:0] ld_cnt_q, ld_cnt_d, st_cnt_q, st_cnt_d;
   logic [GntWidth-1:0] grant_cnt_q, grant_cnt_d, grant_inc;
   logic                last_ld_q, last_ld_d;
   logic                err_q, err_d;
   logic                ld_issue_ok, st_issue_ok, ar_hs, aw_hs;

   assign ld_issue_ok    = (state_q == StLd) && (ld_cnt_q < MaxCnt);
   assign st_issue_ok    = (state_q == StSt) && (st_cnt_q < MaxCnt);
   assign ar_valid_o     = ld_req_valid_i & ld_issue_ok;
   assign ld_req_ready_o = ar_ready_i & ld_issue_ok;
   assign aw_valid_o     = st_req_valid_i & st_issue_ok;
   assign st_req_ready_o = aw_ready_i & st_issue_ok;
   assign ar_hs          = ar_valid_o & ar_ready_i;
   assign aw_hs          = aw_valid_o & aw_ready_i;

   // Include this cycle's grant so the switch lands on the edge of the Nth grant, not N+1.
   assign grant_inc = ((ar_hs | aw_hs) && (grant_cnt_q != ThrCnt)) ? grant_cnt_q + 1'b1
                                                                   : grant_cnt_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (ld_req_valid_i && (!st_req_valid_i || !last_ld_q)) state_d = StLd;
            else if (st_req_valid_i)                               state_d = StSt;
         end
         StLd: begin
            if (st_req_valid_i && (!ld_req_valid_i || grant_inc >= ThrCnt)) state_d = StDrainLd;
            else if (!ld_req_valid_i && !st_req_valid_i && ld_cnt_q == '0)  state_d = StIdle;
         end
         StSt: begin
            if (ld_req_valid_i && (!st_req_valid_i || grant_inc >= ThrCnt)) state_d = StDrainSt;
            else if (!ld_req_valid_i && !st_req_valid_i && st_cnt_q == '0)  state_d = StIdle;
         end
         StDrainLd: if (ld_cnt_q == '0) state_d = StSt;
         StDrainSt: if (st_cnt_q == '0) state_d = StLd;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      grant_cnt_d = (state_d != state_q) ? '0 : grant_inc;
      last_ld_d   = last_ld_q;
      if (state_d == StLd && state_q != StLd) last_ld_d = 1'b1;
      if (state_d == StSt && state_q != StSt) last_ld_d = 1'b0;
   end

   // Issue and completion in the same cycle cancel; a completion at zero is an error, no wrap.
   always_comb begin
      ld_cnt_d = ld_cnt_q;
      st_cnt_d = st_cnt_q;
      err_d    = err_q;
      if (ar_hs && !r_last_hs_i) begin
         ld_cnt_d = ld_cnt_q + 1'b1;
      end else if (!ar_hs && r_last_hs_i) begin
         if (ld_cnt_q == '0) err_d = 1'b1;
         else                ld_cnt_d = ld_cnt_q - 1'b1;
      end
      if (aw_hs && !b_hs_i) begin
         st_cnt_d = st_cnt_q + 1'b1;
      end else if (!aw_hs && b_hs_i) begin
         if (st_cnt_q == '0) err_d = 1'b1;
         else                st_cnt_d = st_cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         ld_cnt_q    <= '0;
         st_cnt_q    <= '0;
         grant_cnt_q <= '0;
         last_ld_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ld_cnt_q    <= ld_cnt_d;
         st_cnt_q    <= st_cnt_d;
         grant_cnt_q <= grant_cnt_d;
         last_ld_q   <= last_ld_d;
         err_q       <= err_d;
      end
   end

`ifdef VLSU_TXN_SCHED_PERF_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         perf_q <= '0;
      end else if (state_d != state_q && (state_d == StDrainLd || state_d == StDrainSt)) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign perf_switches_o = perf_q;
`else
   assign perf_switches_o = '0;
`endif

   assign ld_outstanding_o = ld_cnt_q;
   assign st_outstanding_o = st_cnt_q;
   assign idle_o           = (state_q == StIdle) && (ld_cnt_q == '0) && (st_cnt_q == '0);
   assign err_o            = err_q;

endmodule

// File: tb/tb_vlsu_txn_sched.sv
// Self-checking bench for vlsu_txn_sched: expected grant order is queued as stimulus is
// driven and popped as AR/AW handshakes appear; state/counter checks are inline.
module tb_vlsu_txn_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ld_req_valid = 1'b0, st_req_valid = 1'b0;
   logic        ld_req_ready, st_req_ready;
   logic        ar_valid, aw_valid;
   logic        ar_ready = 1'b1, aw_ready = 1'b1;
   logic        r_last_hs = 1'b0, b_hs = 1'b0;
   logic [3:0]  ld_out, st_out;
   logic        idle, err;
   logic [31:0] perf;

   int          n_total = 0;
   int          n_bad   = 0;
   logic [7:0]  exp_q[$];
   logic        ar_hs_seen, aw_hs_seen;

   vlsu_txn_sched dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .ld_req_valid_i   (ld_req_valid),
      .ld_req_ready_o   (ld_req_ready),
      .st_req_valid_i   (st_req_valid),
      .st_req_ready_o   (st_req_ready),
      .ar_valid_o       (ar_valid),
      .ar_ready_i       (ar_ready),
      .aw_valid_o       (aw_valid),
      .aw_ready_i       (aw_ready),
      .r_last_hs_i      (r_last_hs),
      .b_hs_i           (b_hs),
      .ld_outstanding_o (ld_out),
      .st_outstanding_o (st_out),
      .idle_o           (idle),
      .err_o            (err),
      .perf_switches_o  (perf)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Sample at the falling edge and pop the scoreboard for any handshake seen.
   task automatic neg();
      @(negedge clk);
      ar_hs_seen = !rst && ar_valid && ar_ready;
      aw_hs_seen = !rst && aw_valid && aw_ready;
      if (ar_hs_seen) begin
         if (exp_q.size() == 0) check_eq("unexpected_ar", 1, 0);
         else                   check_eq("order_ar", 8'h4C, exp_q.pop_front());
      end
      if (aw_hs_seen) begin
         if (exp_q.size() == 0) check_eq("unexpected_aw", 1, 0);
         else                   check_eq("order_aw", 8'h53, exp_q.pop_front());
      end
   endtask

   task automatic pos();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_n(input bit ld, input int n, input bit keep);
      int got = 0;
      for (int i = 0; i < n; i++) exp_q.push_back(ld ? 8'h4C : 8'h53);
      if (ld) ld_req_valid = 1'b1;
      else    st_req_valid = 1'b1;
      for (int c = 0; c < 200 && got < n; c++) begin
         neg();
         if (ld ? ar_hs_seen : aw_hs_seen) got++;
         pos();
      end
      if (!keep) begin
         if (ld) ld_req_valid = 1'b0;
         else    st_req_valid = 1'b0;
      end
      check_eq(ld ? "drive_ld_count" : "drive_st_count", got, n);
   endtask

   task automatic pulse_r(input int n);
      for (int i = 0; i < n; i++) begin
         r_last_hs = 1'b1;
         neg();
         pos();
      end
      r_last_hs = 1'b0;
   endtask

   task automatic pulse_b(input int n);
      for (int i = 0; i < n; i++) begin
         b_hs = 1'b1;
         neg();
         pos();
      end
      b_hs = 1'b0;
   endtask

   initial begin
      int grants;
      // Reset: requests asserted but everything must stay quiet
      ld_req_valid = 1'b1;
      st_req_valid = 1'b1;
      pos();
      pos();
      check_eq("rst_ld_out", ld_out, 0);
      check_eq("rst_st_out", st_out, 0);
      check_eq("rst_idle", idle, 1);
      check_eq("rst_err", err, 0);
      check_eq("rst_perf", perf, 0);
      check_eq("rst_valids", {ar_valid, aw_valid, ld_req_ready, st_req_ready}, 0);
      ld_req_valid = 1'b0;
      st_req_valid = 1'b0;
      rst = 1'b0;
      pos();

      // Load-only: 3 bursts out, 3 completions back
      drive_n(1'b1, 3, 1'b0);
      check_eq("lo_ld_out3", ld_out, 3);
      pulse_r(3);
      check_eq("lo_ld_out0", ld_out, 0);
      pos();
      neg();
      check_eq("lo_idle", idle, 1);
      pos();

      // Credit limit: 8 grants, then blocked until a completion
      drive_n(1'b1, 8, 1'b1);
      check_eq("cr_ld_out8", ld_out, 8);
      for (int i = 0; i < 5; i++) begin
         neg();
         check_eq("cr_blocked_ready", ld_req_ready, 0);
         check_eq("cr_blocked_valid", ar_valid, 0);
         pos();
      end
      exp_q.push_back(8'h4C);
      r_last_hs = 1'b1;
      neg();
      check_eq("cr_same_cycle_blocked", ar_valid, 0);
      pos();
      r_last_hs = 1'b0;
      neg();
      check_eq("cr_unblocked", ar_valid, 1);
      pos();
      ld_req_valid = 1'b0;
      check_eq("cr_ld_out_refill", ld_out, 8);
      pulse_r(8);
      pos();
      neg();
      check_eq("cr_idle", idle, 1);
      pos();

      // Switch/drain: store waits for both outstanding loads
      drive_n(1'b1, 2, 1'b0);
      st_req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         neg();
         check_eq("sw_aw_held", aw_valid, 0);
         pos();
      end
      for (int i = 0; i < 2; i++) begin
         r_last_hs = 1'b1;
         neg();
         check_eq("sw_aw_held_pulse", aw_valid, 0);
         pos();
      end
      r_last_hs = 1'b0;
      neg();
      check_eq("sw_aw_held_drained", aw_valid, 0);
      pos();
      exp_q.push_back(8'h53);
      exp_q.push_back(8'h53);
      exp_q.push_back(8'h53);
      neg();
      check_eq("sw_aw_released", aw_valid, 1);
      pos();
      neg();
      pos();
      check_eq("sim_st_out2", st_out, 2);

      // Issue and completion together leave the count alone
      b_hs = 1'b1;
      neg();
      pos();
      b_hs = 1'b0;
      st_req_valid = 1'b0;
      check_eq("sim_st_out_hold", st_out, 2);
      pulse_b(2);
      check_eq("sim_st_out0", st_out, 0);
      check_eq("err_clear", err, 0);
      pulse_b(1);
      check_eq("err_set", err, 1);
      check_eq("err_no_wrap", st_out, 0);
      pos();
      pos();
      pos();
      check_eq("err_sticky", err, 1);

      // Fairness: both directions requesting, completions returned as soon as possible
      for (int r = 0; r < 6; r++)
         for (int k = 0; k < 4; k++) exp_q.push_back((r % 2 == 0) ? 8'h4C : 8'h53);
      ld_req_valid = 1'b1;
      st_req_valid = 1'b1;
      grants = 0;
      for (int c = 0; c < 300 && grants < 24; c++) begin
         r_last_hs = (ld_out != 0);
         b_hs      = (st_out != 0);
         neg();
         if (ar_hs_seen && grants == 8) begin
`ifdef VLSU_TXN_SCHED_PERF_EN
            check_eq("fair_perf", perf, 2);
`else
            check_eq("fair_perf", perf, 0);
`endif
         end
         if (ar_hs_seen || aw_hs_seen) grants++;
         pos();
      end
      check_eq("fair_grants", grants, 24);
      ld_req_valid = 1'b0;
      st_req_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         r_last_hs = (ld_out != 0);
         b_hs      = (st_out != 0);
         neg();
         pos();
      end
      r_last_hs = 1'b0;
      b_hs      = 1'b0;
      neg();
      check_eq("fair_idle", idle, 1);
      pos();

      // Asynchronous reset between edges, mid-burst
      drive_n(1'b1, 3, 1'b1);
      check_eq("ar_pre_ld_out", ld_out, 3);
      check_eq("ar_pre_valid", ar_valid, 1);
      #2 rst = 1'b1;
      #1;
      check_eq("ar_ld_out", ld_out, 0);
      check_eq("ar_st_out", st_out, 0);
      check_eq("ar_valids", {ar_valid, aw_valid, ld_req_ready, st_req_ready}, 0);
      check_eq("ar_err", err, 0);
      check_eq("ar_perf", perf, 0);
      ld_req_valid = 1'b0;
      pos();
      rst = 1'b0;
      pulse_r(1);
      check_eq("ar_stale_completion_err", err, 1);
      check_eq("sb_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
